seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 91 +++++++++
 tb/tb_seg_scan_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-seg scan with double-buffered load; SEG_SCAN_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1000,
  parameter int DIGIT_TICKS = 16,
  parameter int BLANK_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              dec_bin,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(DIGIT_TICKS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_TICKS - 1);
  localparam logic [SW-1:0] DRIVE_LAST = SW'(DIGIT_TICKS - BLANK_TICKS - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]           digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d, pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d, lz;
  logic [6:0]              seg_q, seg_d;
  logic                    tick, done, frame_end, accept, lit;
  assign load_ready = !pending_full_q && !rst;
  assign dec_bin    = active_q[{digit_idx_q, 2'b00} +: 4];
  assign an         = an_q;
  assign seg        = seg_q;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic z;
    z  = 1'b1;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      z     = z && (active_q[4*i +: 4] == 4'h0);
      lz[i] = z;
    end
  end
`else
  always_comb lz = '0;
`endif
  always_comb begin
    tick           = tick_cnt_q == TICK_LAST;
    tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
    done           = tick && slot_cnt_q == (state_q == BLANK ? BLANK_LAST : DRIVE_LAST);
    slot_cnt_d     = !tick ? slot_cnt_q : done ? '0 : slot_cnt_q + 1'b1;
    state_d        = done ? (state_q == BLANK ? DRIVE : BLANK) : state_q;
    frame_end      = done && state_q == DRIVE && digit_idx_q == DIG_LAST;
    digit_idx_d    = (done && state_q == DRIVE) ? (frame_end ? '0 : digit_idx_q + 1'b1) : digit_idx_q;
    accept         = load_valid && load_ready;
    active_d       = (frame_end && pending_full_q) ? pending_q : active_q;
    pending_d      = accept ? load_data : pending_q;
    pending_full_d = accept || (pending_full_q && !frame_end);
    lit            = state_d == DRIVE && !lz[digit_idx_d];
    an_d           = lit ? ~(NUM_DIGITS'(1) << digit_idx_d) : '1;
    seg_d          = lit ? dec_seg : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BLANK;
      tick_cnt_q     <= '0;
      slot_cnt_q     <= '0;
      digit_idx_q    <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      an_q           <= '1;
      seg_q          <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      digit_idx_q    <= digit_idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench with a frame-time reference model for seg_scan_ctrl
module tb_seg_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, load_valid = 1'b0, load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  dec_bin, an;
  logic [6:0]  dec_seg, seg;
  int          n_chk = 0, n_fail = 0, t = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  bit          m_pf = 0;
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] bin;
    bit         pf;
    int         t;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  function automatic bit dark(input int d, input logic [15:0] a);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    return d != 0 && (a >> (4 * d)) == 16'h0;
`else
    return (d < 0) && (a == a);
`endif
  endfunction
  assign dec_seg = seg7(dec_bin);
  seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .DIGIT_TICKS(4), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .dec_bin(dec_bin), .dec_seg(dec_seg), .seg(seg), .an(an)
  );
  always @(posedge clk) begin
    exp_t e;
    int   pos, d;
    bit   lit, acc, fb;
    if (rst) begin
      t = 0; m_act = '0; m_pend = '0; m_pf = 0;
    end else begin
      acc = load_valid && !m_pf;
      fb  = (t % 64) == 63;
      if (fb && m_pf) begin m_act = m_pend; m_pf = 0; end
      if (acc) begin m_pend = load_data; m_pf = 1; end
      t++;
    end
    pos   = t % 16;
    d     = (t / 16) % 4;
    lit   = pos >= 4 && !dark(d, m_act);
    e.an  = lit ? ~(4'b0001 << d) : 4'hF;
    e.bin = m_act[4*d +: 4];
    e.seg = lit ? seg7(e.bin) : 7'h00;
    e.pf  = m_pf;
    e.t   = t;
    q.push_back(e);
  end
  task automatic check(input string name, input int tt, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, tt, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("an", e.t, 32'(an), 32'(e.an));
      check("seg", e.t, 32'(seg), 32'(e.seg));
      check("dec_bin", e.t, 32'(dec_bin), 32'(e.bin));
      check("load_ready", e.t, 32'(load_ready), 32'(!rst && !e.pf));
    end
  end
  task automatic send(input logic [15:0] d);
    bit ok = 0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = load_ready;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout data=%h actual=not_accepted required=accepted", d);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(16'h1234);
    idle(140);
    send(16'hABCD);
    send(16'h0009);
    idle(200);
    send(16'h5678);
    for (int i = 0; i < 200 && (t % 64) != 40; i++) idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(70);
    send(16'h0050);
    idle(140);
    send(16'h0000);
    idle(140);
    repeat (12) begin
      idle($urandom_range(0, 80));
      send(16'($urandom));
    end
    repeat (20) begin
      load_valid = 1'b1;
      load_data  = 16'($urandom);
      idle(1);
      load_valid = 1'b0;
      idle($urandom_range(0, 40));
    end
    idle(140);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
